multicycle_control: RTL

- Parametrised successor to the single-cycle control decoder, for the multicycle CPU core.
- A state machine that sequences each instruction through IF/ID/EX/MEM/WB and drives per-cycle datapath strobes.
- Waits on a memory ready handshake and supports HLT.
- Keeps a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/alu_op_decode.sv | 58 +++++
 rtl/multicycle_control.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg: opcode/func codes, FSM states and datapath mux encodings shared by
// the multicycle and single-cycle cores.        Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int unsigned c_opBne = 0;
  localparam int unsigned c_opBeq = 1;
  localparam int unsigned c_opBgz = 2;
  localparam int unsigned c_opBlz = 3;
  localparam int unsigned c_opAdi = 4;
  localparam int unsigned c_opOri = 5;
  localparam int unsigned c_opLhi = 6;
  localparam int unsigned c_opLwd = 7;
  localparam int unsigned c_opSwd = 8;
  localparam int unsigned c_opJmp = 9;
  localparam int unsigned c_opJal = 10;
  localparam int unsigned c_opR   = 15;

  localparam int unsigned c_fnWwd = 28;
  localparam int unsigned c_fnJpr = 25;
  localparam int unsigned c_fnJrl = 26;
  localparam int unsigned c_fnHlt = 29;

  localparam int unsigned c_aluAdd = 0;
  localparam int unsigned c_aluOr  = 3;
  localparam int unsigned c_aluLhi = 8;
  localparam int unsigned c_aluBne = 9;
  localparam int unsigned c_aluBeq = 10;
  localparam int unsigned c_aluBgz = 11;
  localparam int unsigned c_aluBlz = 12;

  localparam logic [1:0] c_pcSrcPc1    = 2'd0;
  localparam logic [1:0] c_pcSrcBranch = 2'd1;
  localparam logic [1:0] c_pcSrcJump   = 2'd2;
  localparam logic [1:0] c_pcSrcReg    = 2'd3;

  localparam logic [1:0] c_regDstRt = 2'd0;
  localparam logic [1:0] c_regDstRd = 2'd1;
  localparam logic [1:0] c_regDstR2 = 2'd2;

  localparam logic [1:0] c_memToRegAlu = 2'd0;
  localparam logic [1:0] c_memToRegMdr = 2'd1;
  localparam logic [1:0] c_memToRegPc1 = 2'd2;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       aluSrc;
    logic       openPort;
  } strobes_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
//------------------------------------------------------------------------------
// multicycle_control_if: instruction/handshake inputs and datapath strobes
// between the multicycle controller and its datapath.        Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_if #(
  parameter int OP_W    = 4,
  parameter int FUNC_W  = 6,
  parameter int ALUOP_W = 4
);
  logic [OP_W-1:0]    opcode;
  logic [FUNC_W-1:0]  func;
  logic               mem_ready;
  logic               branch_taken;

  logic               mem_read;
  logic               mem_write;
  logic               i_or_d;
  logic               ir_write;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic               reg_write;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               open_port;

  modport master (
    input  opcode, func, mem_ready, branch_taken,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, alu_src, alu_op, open_port
  );

  modport slave (
    output opcode, func, mem_ready, branch_taken,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, alu_src, alu_op, open_port
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_decode.sv
//------------------------------------------------------------------------------
// alu_op_decode: combinational ALU operation / operand-B select table.
//                                                   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_op_decode
  import cpu_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNC_W  = 6,
  parameter int ALUOP_W = 4
) (
  input  wire logic [OP_W-1:0]    i_opcode,
  input  wire logic [FUNC_W-1:0]  i_func,
  output logic      [ALUOP_W-1:0] o_aluOp,
  output logic                    o_aluSrc
);

  logic [31:0] w_op;
  logic [31:0] w_fn;

  always_comb begin
    w_op     = 32'(i_opcode);
    w_fn     = 32'(i_func);
    o_aluOp  = '0;
    o_aluSrc = 1'b0;
    case (w_op)
      c_opR: begin
        // Only the low eight funcs are ALU ops; jumps/WWD/HLT leave the ALU at ADD.
        if (w_fn < 32'd8) o_aluOp = ALUOP_W'(w_fn);
      end
      c_opAdi, c_opLwd, c_opSwd: begin
        o_aluOp  = ALUOP_W'(c_aluAdd);
        o_aluSrc = 1'b1;
      end
      c_opOri: begin
        o_aluOp  = ALUOP_W'(c_aluOr);
        o_aluSrc = 1'b1;
      end
      c_opLhi: begin
        o_aluOp  = ALUOP_W'(c_aluLhi);
        o_aluSrc = 1'b1;
      end
      c_opBne: o_aluOp = ALUOP_W'(c_aluBne);
      c_opBeq: o_aluOp = ALUOP_W'(c_aluBeq);
      c_opBgz: o_aluOp = ALUOP_W'(c_aluBgz);
      c_opBlz: o_aluOp = ALUOP_W'(c_aluBlz);
      default: begin
        o_aluOp  = '0;
        o_aluSrc = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// multicycle_control: IF/ID/EX/MEM/WB sequencer with memory-ready stalls, HLT
// and a retired-instruction counter.                Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import cpu_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNC_W  = 6,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  multicycle_control_if.master  bus,
  output logic                  halted,
  output logic [CNT_W-1:0]      num_inst
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_numInst;
  logic               w_retire;
  strobes_t           w_str;
  logic [ALUOP_W-1:0] w_aluOp;
  logic [ALUOP_W-1:0] w_decAluOp;
  logic               w_decAluSrc;
  logic [31:0]        w_op;
  logic [31:0]        w_fn;
  logic               w_isR;
  logic               w_isRAlu;
  logic               w_isBranch;
  logic               w_isImm;
  logic               w_isMem;

  assign w_op       = 32'(bus.opcode);
  assign w_fn       = 32'(bus.func);
  assign w_isR      = (w_op == c_opR);
  assign w_isRAlu   = w_isR && (w_fn < 32'd8);
  assign w_isBranch = (w_op <= c_opBlz);
  assign w_isImm    = (w_op == c_opAdi) || (w_op == c_opOri) || (w_op == c_opLhi);
  assign w_isMem    = (w_op == c_opLwd) || (w_op == c_opSwd);

  alu_op_decode #(
    .OP_W    (OP_W),
    .FUNC_W  (FUNC_W),
    .ALUOP_W (ALUOP_W)
  ) u_aluOpDecode (
    .i_opcode (bus.opcode),
    .i_func   (bus.func),
    .o_aluOp  (w_decAluOp),
    .o_aluSrc (w_decAluSrc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IF;
      r_numInst <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_numInst <= r_numInst + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_str    = '0;
    w_aluOp  = '0;
    case (r_state)
      ST_IF: begin
        w_str.memRead = 1'b1;
        if (bus.mem_ready) begin
          w_str.irWrite = 1'b1;
          w_next        = ST_ID;
        end
      end
      ST_ID: begin
        if (w_isR && (w_fn == c_fnHlt)) begin
          w_retire = 1'b1;
          w_next   = ST_HALT;
        end else if (w_isRAlu || w_isBranch || w_isImm || w_isMem) begin
          w_next = ST_EX;
        end else begin
          // Jumps, WWD and unknown encodings all complete here.
          w_str.pcWrite = 1'b1;
          w_retire      = 1'b1;
          w_next        = ST_IF;
          if (w_isR && (w_fn == c_fnWwd)) w_str.openPort = 1'b1;
          if (w_isR && ((w_fn == c_fnJpr) || (w_fn == c_fnJrl))) w_str.pcSrc = c_pcSrcReg;
          if (!w_isR && ((w_op == c_opJmp) || (w_op == c_opJal))) w_str.pcSrc = c_pcSrcJump;
          if ((w_isR && (w_fn == c_fnJrl)) || (!w_isR && (w_op == c_opJal))) begin
            w_str.regWrite = 1'b1;
            w_str.regDst   = c_regDstR2;
            w_str.memToReg = c_memToRegPc1;
          end
        end
      end
      ST_EX: begin
        w_aluOp      = w_decAluOp;
        w_str.aluSrc = w_decAluSrc;
        if (w_isBranch) begin
          w_str.pcWrite = 1'b1;
          w_str.pcSrc   = bus.branch_taken ? c_pcSrcBranch : c_pcSrcPc1;
          w_retire      = 1'b1;
          w_next        = ST_IF;
        end else if (w_isMem) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        w_str.iOrD = 1'b1;
        if (w_op == c_opSwd) begin
          w_str.memWrite = 1'b1;
          if (bus.mem_ready) begin
            w_str.pcWrite = 1'b1;
            w_retire      = 1'b1;
            w_next        = ST_IF;
          end
        end else begin
          w_str.memRead = 1'b1;
          if (bus.mem_ready) w_next = ST_WB;
        end
      end
      ST_WB: begin
        w_str.regWrite = 1'b1;
        w_str.pcWrite  = 1'b1;
        w_str.regDst   = w_isR ? c_regDstRd : c_regDstRt;
        w_str.memToReg = (w_op == c_opLwd) ? c_memToRegMdr : c_memToRegAlu;
        w_retire       = 1'b1;
        w_next         = ST_IF;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IF;
    endcase
    // Reset silences the datapath in the same cycle, even mid-access.
    if (reset) begin
      w_str   = '0;
      w_aluOp = '0;
    end
  end

  assign bus.mem_read   = w_str.memRead;
  assign bus.mem_write  = w_str.memWrite;
  assign bus.i_or_d     = w_str.iOrD;
  assign bus.ir_write   = w_str.irWrite;
  assign bus.pc_write   = w_str.pcWrite;
  assign bus.pc_src     = w_str.pcSrc;
  assign bus.reg_write  = w_str.regWrite;
  assign bus.reg_dst    = w_str.regDst;
  assign bus.mem_to_reg = w_str.memToReg;
  assign bus.alu_src    = w_str.aluSrc;
  assign bus.alu_op     = w_aluOp;
  assign bus.open_port  = w_str.openPort;

  assign halted   = !reset && (r_state == ST_HALT);
  assign num_inst = reset ? '0 : r_numInst;

endmodule

`default_nettype wire
